// File: rtl/nibble_serial_subtractor_if.sv
// Handshake and data bundle for the nibble-serial subtractor.
// The requester drives START and the operands; the subtractor drives the status and result.
`timescale 1ns/1ps
interface nibble_serial_subtractor_if #(parameter int WIDTH = 8);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             Z;

  modport master (output START, A, B, BIN, input BUSY, DONE, D, BOUT, Z);
  modport slave  (input START, A, B, BIN, output BUSY, DONE, D, BOUT, Z);
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: D = A - B - BIN, one 4-bit slice per clock, LSB nibble first.
// Each slice is a 4-bit add-with-carry run as A + ~B + ~borrow.
//
//   state  | meaning
//   IDLE   | waiting for START
//   RUN    | one nibble processed per edge, result shifting into part_reg
//   DONE_S | one-cycle DONE pulse; START here begins the next operation
`timescale 1ns/1ps
module nibble_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    CLR_N,
  nibble_serial_subtractor_if.slave bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DONE_S = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] part_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow;
  logic             bout_reg;
  logic             z_reg;
  logic [CW-1:0]    cnt;

  logic [4:0]       sum5;
  logic [WIDTH-1:0] result;

  // Operands shift right every RUN edge, so the active slice is always bits [3:0].
  always_comb begin
    sum5 = {1'b0, a_reg[3:0]} + {1'b0, ~b_reg[3:0]} + {4'b0000, ~borrow};
  end

  generate
    if (WIDTH == 4) begin : g_single
      always_comb result = sum5[3:0];
    end else begin : g_multi
      always_comb result = {sum5[3:0], part_reg[WIDTH-1:4]};
    end
  endgenerate

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      part_reg <= '0;
      d_reg    <= '0;
      borrow   <= 1'b0;
      bout_reg <= 1'b0;
      z_reg    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE_S: begin
          if (bus.START) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            borrow   <= bus.BIN;
            part_reg <= '0;
            cnt      <= '0;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg    <= a_reg >> 4;
          b_reg    <= b_reg >> 4;
          borrow   <= ~sum5[4];
          part_reg <= result;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            d_reg    <= result;
            bout_reg <= ~sum5[4];
            z_reg    <= (result == '0);
            cnt      <= '0;
            state    <= DONE_S;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY = (state == RUN);
  assign bus.DONE = (state == DONE_S);
  assign bus.D    = d_reg;
  assign bus.BOUT = bout_reg;
  assign bus.Z    = z_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed cases plus a random sweep at WIDTH=8 and 16,
// checked against an arithmetic reference (A - B - BIN modulo 2^(WIDTH+1)).
`timescale 1ns/1ps
module tb_nibble_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_subtractor_if #(.WIDTH(8))  bus8();
  nibble_serial_subtractor_if #(.WIDTH(16)) bus16();

  nibble_serial_subtractor #(.WIDTH(8))  dut8  (.CLK(clk), .CLR_N(rst_n), .bus(bus8));
  nibble_serial_subtractor #(.WIDTH(16)) dut16 (.CLK(clk), .CLR_N(rst_n), .bus(bus16));

  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic [15:0] a_s = '0;
  logic [15:0] b_s = '0;
  logic        bin_s = 1'b0;

  assign bus8.START  = start8;
  assign bus8.A      = a_s[7:0];
  assign bus8.B      = b_s[7:0];
  assign bus8.BIN    = bin_s;
  assign bus16.START = start16;
  assign bus16.A     = a_s;
  assign bus16.B     = b_s;
  assign bus16.BIN   = bin_s;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs_d(input int w);
    return (w == 8) ? {8'h00, bus8.D} : bus16.D;
  endfunction
  function automatic logic obs_busy(input int w);
    return (w == 8) ? bus8.BUSY : bus16.BUSY;
  endfunction
  function automatic logic obs_done(input int w);
    return (w == 8) ? bus8.DONE : bus16.DONE;
  endfunction
  function automatic logic obs_bout(input int w);
    return (w == 8) ? bus8.BOUT : bus16.BOUT;
  endfunction
  function automatic logic obs_z(input int w);
    return (w == 8) ? bus8.Z : bus16.Z;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else        start16 = v;
  endtask

  // Reference: {BOUT, D} = A - B - BIN in WIDTH+1 bits.
  function automatic logic [16:0] ref_sub(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
    logic [15:0] m;
    logic [16:0] m17;
    m   = (w == 8) ? 16'h00FF : 16'hFFFF;
    m17 = (w == 8) ? 17'h001FF : 17'h1FFFF;
    return ({1'b0, a & m} - {1'b0, b & m} - 17'(bin)) & m17;
  endfunction

  // Called just after the accepting edge; returns edges counted until DONE is seen.
  task automatic wait_done(input int w, input bit pulse, output int edges);
    logic [15:0] hold;
    bit got;
    hold  = obs_d(w);
    got   = 1'b0;
    edges = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      chk("busy_done_excl", 32'(obs_busy(w) & obs_done(w)), 32'd0);
      if (obs_done(w)) got = 1'b1;
      else begin
        chk("busy_in_run", 32'(obs_busy(w)), 32'd1);
        chk("d_hold_in_run", 32'(obs_d(w)), 32'(hold));
        if (pulse) set_start(w, edges == 1);
      end
    end
    if (pulse) set_start(w, 1'b0);
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] got_d, output logic got_bout);
    logic [16:0] r;
    logic [15:0] m;
    int edges;
    m = (w == 8) ? 16'h00FF : 16'hFFFF;
    r = ref_sub(w, a, b, bin);
    @(negedge clk);
    a_s = a; b_s = b; bin_s = bin;
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    set_start(w, 1'b0);
    a_s = 16'($urandom); b_s = 16'($urandom); bin_s = 1'($urandom);
    wait_done(w, 1'b1, edges);
    chk("latency", 32'(edges), 32'(w / 4));
    chk("d", 32'(obs_d(w)), 32'(r[15:0] & m));
    chk("bout", 32'(obs_bout(w)), 32'(r[w]));
    chk("z", 32'(obs_z(w)), 32'((r[15:0] & m) == 16'h0000));
    got_d = obs_d(w);
    got_bout = obs_bout(w);
    @(negedge clk);
    chk("done_one_cycle", 32'(obs_done(w)), 32'd0);
    chk("idle_after_done", 32'(obs_busy(w)), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    logic bo;
    int edges;

    #2;
    chk("rst_busy", 32'({bus8.BUSY, bus16.BUSY}), 32'd0);
    chk("rst_done", 32'({bus8.DONE, bus16.DONE}), 32'd0);
    chk("rst_d", 32'({bus8.D, bus16.D}), 32'd0);
    chk("rst_bout_z", 32'({bus8.BOUT, bus8.Z, bus16.BOUT, bus16.Z}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8, 16'h53, 16'h21, 1'b0, d, bo);
    chk("d_53_21", 32'(d), 32'h32);
    do_op(8, 16'h10, 16'h01, 1'b0, d, bo);
    chk("d_10_01", 32'(d), 32'h0F);
    do_op(8, 16'h00, 16'h01, 1'b0, d, bo);
    chk("wrap_00_01", 32'({bo, d[7:0]}), 32'h1FF);
    do_op(8, 16'h05, 16'h05, 1'b0, d, bo);
    chk("z_05_05", 32'(bus8.Z), 32'd1);
    do_op(8, 16'h05, 16'h05, 1'b1, d, bo);
    chk("bin_05_05", 32'({bo, d[7:0]}), 32'h1FF);

    // Back-to-back: START held high; next pair presented while the first is running.
    @(negedge clk);
    a_s = 16'h80; b_s = 16'h7F; bin_s = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    a_s = 16'h00; b_s = 16'hFF;
    wait_done(8, 1'b0, edges);
    chk("b2b1_latency", 32'(edges), 32'd2);
    chk("b2b1_result", 32'({bus8.BOUT, bus8.D}), 32'h001);
    @(posedge clk);
    #1;
    chk("b2b_accept", 32'(bus8.BUSY), 32'd1);
    wait_done(8, 1'b0, edges);
    start8 = 1'b0;
    chk("b2b2_latency", 32'(edges), 32'd2);
    chk("b2b2_result", 32'({bus8.BOUT, bus8.D}), 32'h101);

    // Reset asserted while RUN is in progress.
    @(negedge clk);
    a_s = 16'h53; b_s = 16'h21; bin_s = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus8.BUSY), 32'd0);
    chk("midrst_done", 32'(bus8.DONE), 32'd0);
    chk("midrst_d", 32'(bus8.D), 32'd0);
    chk("midrst_bout_z", 32'({bus8.BOUT, bus8.Z}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(bus8.DONE), 32'd0);
    end
    do_op(8, 16'h9A, 16'h2B, 1'b0, d, bo);
    chk("after_rst_9a_2b", 32'({bo, d[7:0]}), 32'h06F);

    for (int i = 0; i < 120; i++)
      do_op(8, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), d, bo);
    for (int i = 0; i < 120; i++)
      do_op(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), d, bo);
    do_op(16, 16'h0000, 16'hFFFF, 1'b1, d, bo);
    do_op(16, 16'h1234, 16'h1233, 1'b1, d, bo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
